// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the parametrised data stack.
//   - opcode constants OP_NOP .. OP_CLEAR (codes 0-3 match the previous
//     fixed 16-bit stack)
//   - need_min(op): minimum depth an op requires before it may execute
//   - grows(op):    depth change of an op (+1 / 0 / -1); CLEAR is handled
//                   separately because it resets depth rather than stepping it
package stack_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_BINOP = 3'd2;
  localparam logic [2:0] OP_DROP  = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_OVER  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  function automatic logic [1:0] need_min(input logic [2:0] op);
    logic [1:0] n;
    case (op)
      OP_BINOP, OP_SWAP, OP_OVER: n = 2'd2;
      OP_DROP, OP_DUP:            n = 2'd1;
      default:                    n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic signed [1:0] grows(input logic [2:0] op);
    logic signed [1:0] g;
    case (op)
      OP_PUSH, OP_DUP, OP_OVER: g = 2'sd1;
      OP_BINOP, OP_DROP:        g = -2'sd1;
      default:                  g = 2'sd0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x WIDTH storage for the data stack, no reset.
// Ports:
//   CLK                 clock, writes on rising edge
//   ra_a / rd_a         combinational read port (top-of-stack address)
//   ra_b / rd_b         combinational read port (next-on-stack address)
//   we0 / wa0 / wd0     write port 0 (all single-write ops, half of SWAP)
//   we1 / wa1 / wd1     write port 1 (second half of SWAP)
// The array is rounded up to a power of two so wrapped read addresses
// (depth 0 or 1) always land inside it; the caller gates those reads.
module stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic [AW-1:0]    ra_a,
  output logic [WIDTH-1:0] rd_a,
  input  logic [AW-1:0]    ra_b,
  output logic [WIDTH-1:0] rd_b,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1
);

  logic [WIDTH-1:0] mem [2**AW];

  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];

  // The two ports never target the same entry (SWAP writes top and second).
  always_ff @(posedge CLK) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

endmodule

// File: rtl/param_stack_unit.sv
// param_stack_unit: parametrised data stack with top/second outputs for
// the ALU, depth status and error reporting.
// Ports:
//   CLK        clock
//   reset      asynchronous active-low reset (clears depth and all flags)
//   stackOP    operation: NOP PUSH BINOP DROP DUP SWAP OVER CLEAR
//   push_data  value for PUSH, result for BINOP
//   err_clear  clears sticky Overflow/Underflow (a same-cycle set wins)
//   outA/outB  top / second entry, zero when not present
//   depth      entry count 0..DEPTH; empty/full derived from it
//   op_err     one-cycle pulse after a rejected op
//   Overflow   sticky: a rejected op lacked free space
//   Underflow  sticky: a rejected op lacked entries (takes priority)
module param_stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       stackOP,
  input  logic [WIDTH-1:0] push_data,
  input  logic             err_clear,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             op_err,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]    depth_q, depth_nxt;
  logic [AW-1:0]    idx_top, idx_nxt, idx_new;
  logic [WIDTH-1:0] rd_top, rd_nxt;
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;
  logic             is_full;
  logic             lack_entries, lack_space, reject;

  // idx_new is only written when not full, so it always fits in AW bits.
  assign idx_top = AW'(depth_q - DW'(1));
  assign idx_nxt = AW'(depth_q - DW'(2));
  assign idx_new = AW'(depth_q);

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .CLK  (CLK),
    .ra_a (idx_top),
    .rd_a (rd_top),
    .ra_b (idx_nxt),
    .rd_b (rd_nxt),
    .we0  (we0),
    .wa0  (wa0),
    .wd0  (wd0),
    .we1  (we1),
    .wa1  (wa1),
    .wd1  (wd1)
  );

  assign is_full      = (depth_q == DW'(DEPTH));
  assign lack_entries = (depth_q < DW'(need_min(stackOP)));
  assign lack_space   = (grows(stackOP) == 2'sd1) && is_full;
  assign reject       = lack_entries || lack_space;

  always_comb begin
    we0       = 1'b0;
    wa0       = idx_new;
    wd0       = push_data;
    we1       = 1'b0;
    wa1       = idx_nxt;
    wd1       = rd_top;
    depth_nxt = depth_q;
    if (!reject) begin
      case (stackOP)
        OP_PUSH: we0 = 1'b1;
        OP_BINOP: begin
          // Result overwrites the second entry, which becomes the new top.
          we0 = 1'b1;
          wa0 = idx_nxt;
        end
        OP_DUP: begin
          we0 = 1'b1;
          wd0 = rd_top;
        end
        OP_SWAP: begin
          we0 = 1'b1;
          wa0 = idx_top;
          wd0 = rd_nxt;
          we1 = 1'b1;
        end
        OP_OVER: begin
          we0 = 1'b1;
          wd0 = rd_nxt;
        end
        default: ;
      endcase

      if (stackOP == OP_CLEAR)
        depth_nxt = '0;
      else if (grows(stackOP) == 2'sd1)
        depth_nxt = depth_q + DW'(1);
      else if (grows(stackOP) == -2'sd1)
        depth_nxt = depth_q - DW'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      depth_q   <= '0;
      op_err    <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      depth_q   <= depth_nxt;
      op_err    <= reject;
      Underflow <= lack_entries || (Underflow && !err_clear);
      Overflow  <= (lack_space && !lack_entries) || (Overflow && !err_clear);
    end
  end

  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = is_full;
  assign outA  = (depth_q >= DW'(1)) ? rd_top : '0;
  assign outB  = (depth_q >= DW'(2)) ? rd_nxt : '0;

endmodule

// File: tb/tb_param_stack_unit.sv
module tb_param_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);

  logic             CLK = 1'b0;
  logic             reset;
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] push_data;
  logic             err_clear;
  logic [WIDTH-1:0] outA, outB;
  logic [DW-1:0]    depth;
  logic             empty, full, op_err, Overflow, Underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue, back = top of stack.
  logic [WIDTH-1:0] mq[$];
  bit m_ovf, m_unf, m_err;

  param_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .stackOP   (stackOP),
    .push_data (push_data),
    .err_clear (err_clear),
    .outA      (outA),
    .outB      (outB),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .op_err    (op_err),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    m_err = 0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic clr);
    int need;
    bit adds;
    bit under, over;
    logic [WIDTH-1:0] t, n;
    need = 0;
    adds = 0;
    case (op)
      3'd1: adds = 1;
      3'd2: need = 2;
      3'd3: need = 1;
      3'd4: begin need = 1; adds = 1; end
      3'd5: need = 2;
      3'd6: begin need = 2; adds = 1; end
      default: ;
    endcase
    under = mq.size() < need;
    over  = adds && (mq.size() == DEPTH);
    m_err = under || over;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (under) m_unf = 1;
    else if (over) m_ovf = 1;
    if (!m_err) begin
      case (op)
        3'd1: mq.push_back(d);
        3'd2: begin void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(d); end
        3'd3: void'(mq.pop_back());
        3'd4: mq.push_back(mq[mq.size()-1]);
        3'd5: begin
          t = mq.pop_back();
          n = mq.pop_back();
          mq.push_back(t);
          mq.push_back(n);
        end
        3'd6: mq.push_back(mq[mq.size()-2]);
        3'd7: mq.delete();
        default: ;
      endcase
    end
  endtask

  function automatic logic [2*WIDTH+DW+4:0] model_vec();
    int sz;
    logic [WIDTH-1:0] a, b;
    sz = mq.size();
    a = (sz >= 1) ? mq[sz-1] : '0;
    b = (sz >= 2) ? mq[sz-2] : '0;
    return {a, b, DW'(sz), sz == 0, sz == DEPTH, m_err, m_ovf, m_unf};
  endfunction

  // Drives one op for one clock and advances the model; returns #1 after the edge.
  task automatic apply_op(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic clr);
    @(negedge CLK);
    stackOP   = op;
    push_data = d;
    err_clear = clr;
    @(posedge CLK);
    model_step(op, d, clr);
    #1;
    stackOP   = 3'd0;
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stackOP = 3'd0;
    push_data = '0;
    err_clear = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({depth, empty, full} !== {DW'(0), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_depth got depth=%0d empty=%b full=%b exp 0 1 0", depth, empty, full);
    end
    checks++;
    if ({outA, outB} !== '0) begin
      errors++;
      $display("FAIL reset_outs got outA=%h outB=%h exp 0 0", outA, outB);
    end
    checks++;
    if ({op_err, Overflow, Underflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {op_err, Overflow, Underflow});
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    apply_op(3'd1, 16'd1, 1'b0);
    apply_op(3'd1, 16'd2, 1'b0);
    checks++;
    if ({depth, outA, outB} !== {DW'(2), 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL basic_push got depth=%0d outA=%0d outB=%0d exp 2 2 1", depth, outA, outB);
    end
    apply_op(3'd2, 16'd3, 1'b0);
    checks++;
    if ({depth, outA, outB, op_err, Overflow, Underflow} !== {DW'(1), 16'd3, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL basic_binop got depth=%0d outA=%0d outB=%0d flags=%b exp 1 3 0 000",
               depth, outA, outB, {op_err, Overflow, Underflow});
    end
  endtask

  task automatic test_stack_ops();
    apply_op(3'd7, 16'd0, 1'b0);
    apply_op(3'd1, 16'd5, 1'b0);
    apply_op(3'd1, 16'd9, 1'b0);
    apply_op(3'd5, 16'd0, 1'b0);
    checks++;
    if ({outA, outB} !== {16'd5, 16'd9}) begin
      errors++;
      $display("FAIL swap got outA=%0d outB=%0d exp 5 9", outA, outB);
    end
    apply_op(3'd6, 16'd0, 1'b0);
    checks++;
    if ({depth, outA, outB} !== {DW'(3), 16'd9, 16'd5}) begin
      errors++;
      $display("FAIL over got depth=%0d outA=%0d outB=%0d exp 3 9 5", depth, outA, outB);
    end
    apply_op(3'd4, 16'd0, 1'b0);
    checks++;
    if ({depth, outA, outB, full, op_err} !== {DW'(4), 16'd9, 16'd9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dup got depth=%0d outA=%0d outB=%0d full=%b err=%b exp 4 9 9 1 0",
               depth, outA, outB, full, op_err);
    end
  endtask

  task automatic test_overflow();
    apply_op(3'd7, 16'd0, 1'b0);
    for (int i = 1; i <= 4; i++) apply_op(3'd1, 16'(i), 1'b0);
    checks++;
    if ({full, depth, outA} !== {1'b1, DW'(4), 16'd4}) begin
      errors++;
      $display("FAIL full_after_4 got full=%b depth=%0d outA=%0d exp 1 4 4", full, depth, outA);
    end
    apply_op(3'd1, 16'd5, 1'b0);
    checks++;
    if ({Overflow, Underflow, op_err, depth, outA} !== {3'b101, DW'(4), 16'd4}) begin
      errors++;
      $display("FAIL push_overflow got ovf=%b unf=%b err=%b depth=%0d outA=%0d exp 1 0 1 4 4",
               Overflow, Underflow, op_err, depth, outA);
    end
    apply_op(3'd0, 16'd0, 1'b0);
    checks++;
    if ({op_err, Overflow} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_pulse got err=%b ovf=%b exp 0 1", op_err, Overflow);
    end
  endtask

  task automatic test_underflow();
    apply_op(3'd7, 16'd0, 1'b1);
    apply_op(3'd3, 16'd0, 1'b0);
    checks++;
    if ({Underflow, Overflow, op_err, depth} !== {3'b101, DW'(0)}) begin
      errors++;
      $display("FAIL drop_empty got unf=%b ovf=%b err=%b depth=%0d exp 1 0 1 0",
               Underflow, Overflow, op_err, depth);
    end
    apply_op(3'd1, 16'd42, 1'b0);
    apply_op(3'd2, 16'd7, 1'b0);
    checks++;
    if ({depth, outA, op_err} !== {DW'(1), 16'd42, 1'b1}) begin
      errors++;
      $display("FAIL binop_one got depth=%0d outA=%0d err=%b exp 1 42 1", depth, outA, op_err);
    end
    apply_op(3'd0, 16'd0, 1'b1);
    checks++;
    if ({Overflow, Underflow, op_err} !== 3'b000) begin
      errors++;
      $display("FAIL err_clear got ovf=%b unf=%b err=%b exp 000", Overflow, Underflow, op_err);
    end
  endtask

  task automatic test_clear_vs_set();
    apply_op(3'd7, 16'd0, 1'b0);
    apply_op(3'd3, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) apply_op(3'd1, 16'(100 + i), 1'b0);
    apply_op(3'd1, 16'd200, 1'b1);
    checks++;
    if ({Overflow, Underflow, op_err} !== 3'b101) begin
      errors++;
      $display("FAIL clear_vs_set got ovf=%b unf=%b err=%b exp 1 0 1", Overflow, Underflow, op_err);
    end
  endtask

  task automatic test_back_to_back();
    apply_op(3'd4, 16'd0, 1'b0);
    apply_op(3'd6, 16'd0, 1'b0);
    checks++;
    if ({op_err, Overflow, depth, outA, outB} !== {2'b11, DW'(4), 16'd103, 16'd102}) begin
      errors++;
      $display("FAIL back_to_back got err=%b ovf=%b depth=%0d outA=%0d outB=%0d exp 1 1 4 103 102",
               op_err, Overflow, depth, outA, outB);
    end
  endtask

  task automatic test_async_reset();
    apply_op(3'd7, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) apply_op(3'd1, 16'(10 + i), 1'b0);
    apply_op(3'd3, 16'd0, 1'b0);
    apply_op(3'd3, 16'd0, 1'b0);
    apply_op(3'd3, 16'd0, 1'b0);
    apply_op(3'd3, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) apply_op(3'd1, 16'(20 + i), 1'b0);
    @(negedge CLK);
    stackOP = 3'd1;
    push_data = 16'd99;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({depth, outA, outB, op_err, Overflow, Underflow} !== {DW'(0), 16'd0, 16'd0, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got depth=%0d outA=%0d outB=%0d flags=%b exp 0 0 0 000",
               depth, outA, outB, {op_err, Overflow, Underflow});
    end
    model_reset();
    stackOP = 3'd0;
    @(negedge CLK);
    reset = 1'b1;
    apply_op(3'd1, 16'd7, 1'b0);
    checks++;
    if ({depth, outA, outB} !== {DW'(1), 16'd7, 16'd0}) begin
      errors++;
      $display("FAIL push_after_reset got depth=%0d outA=%0d outB=%0d exp 1 7 0", depth, outA, outB);
    end
  endtask

  task automatic test_random();
    logic [2*WIDTH+DW+4:0] obs, exp;
    logic [2:0] op;
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 2) != 0) op = 3'd1;
      apply_op(op, 16'($urandom), ($urandom_range(0, 7) == 0));
      obs = {outA, outB, depth, empty, full, op_err, Overflow, Underflow};
      exp = model_vec();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d] op=%0d got=%h exp=%h", i, op, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stack_ops();
    test_overflow();
    test_underflow();
    test_clear_vs_set();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_stack_unit.md
Name: param_stack_unit

Overview:
- Parametrised data-stack unit for the next-generation stack processor. Replaces the fixed 16-bit push/pop stack.
- Holds up to DEPTH words of WIDTH bits and exposes top-of-stack (outA) and next-on-stack (outB) to the ALU.
- Accepts one stack operation per clock. New operations beyond push, ALU-replace and drop: DUP, SWAP, OVER, CLEAR.
- Provides depth/full/empty status, sticky Overflow/Underflow flags and a per-cycle error pulse.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 16, maximum number of entries (>=2).
- DW, $clog2(DEPTH+1), width of the depth count (derived; do not override).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stackOP  input  3  operation code, encoding below.
- push_data  input  WIDTH  value for PUSH and result for BINOP (driven by the external immediate/ALU mux).
- err_clear  input  1  clears the sticky Overflow/Underflow flags.
- outA  output  WIDTH  top of stack; 0 when depth<1.
- outB  output  WIDTH  second entry; 0 when depth<2.
- depth  output  DW  current entry count, 0..DEPTH.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- op_err  output  1  high for the cycle after a rejected op.
- Overflow  output  1  sticky: a rejected op needed free space.
- Underflow  output  1  sticky: a rejected op needed more entries.

Behaviour:
- Opcodes: 0 NOP, 1 PUSH, 2 BINOP, 3 DROP, 4 DUP, 5 SWAP, 6 OVER, 7 CLEAR. Codes 0-3 match the previous generation.
- Requirements and effects (T=top, N=second):
  - PUSH: needs !full; push push_data; depth+1.
  - BINOP: needs depth>=2; pop T,N, push push_data; depth-1.
  - DROP: needs depth>=1; depth-1.
  - DUP: needs depth>=1 and !full; push T; depth+1.
  - SWAP: needs depth>=2; exchange T and N; depth unchanged.
  - OVER: needs depth>=2 and !full; push N; depth+1.
  - CLEAR: always legal; depth<=0. Does not affect flags.
- Rejected op: stack and depth unchanged; op_err=1 on the next cycle.
  - Sets Overflow when the failing check was !full.
  - Sets Underflow otherwise.
  - Underflow has priority if both checks fail (DUP/OVER with DEPTH too small cannot occur since DEPTH>=2).
- Latency: an op sampled at edge k is visible on outA/outB/depth/empty/full immediately after edge k.
- outA/outB/status are combinational from registered state only; no combinational path from stackOP or push_data to outputs.
- op_err is registered and lasts one cycle per rejected op. Back-to-back rejects keep it high.
- err_clear: clears both sticky flags at the edge. If an error occurs in the same cycle, the set wins for the flag it sets; the other flag clears.
- Reset (reset=0, any time, including mid-op):
  - immediately sets depth=0, Overflow=0, Underflow=0, op_err=0;
  - outA=outB=0;
  - storage contents are not reset and are unobservable while depth is below their index.
- Storage: entry i is valid for i<depth; the top is entry depth-1. No wrap-around: the stack never exceeds DEPTH and never goes below 0.

Decomposition:
- Package stack_pkg holds:
  - opcode localparams (OP_NOP .. OP_CLEAR);
  - function need_min(op), the minimum depth required;
  - function grows(op), which returns +1/0/-1.
- One sub-module: stack_regfile (DEPTH x WIDTH).
  - Two combinational read ports, addressed by depth-1 and depth-2.
  - Two synchronous write ports, used for SWAP and for the single-write ops.
  - No reset.
- Top-level holds the depth counter, legality check, flags and output gating.

Test Plan:
- Reset low for 1 cycle, then PUSH 1, PUSH 2, BINOP with push_data=3 -> depth=1, outA=3, outB=0, no flags.
- PUSH 5, PUSH 9, SWAP -> outA=5, outB=9. OVER -> depth=3, outA=9. DUP -> depth=4, outA=9, outB=9.
- DEPTH=4: PUSH x5 with values 1..5 -> full=1 after the 4th push. The 5th sets Overflow and pulses op_err for 1 cycle; outA stays 4.
- From empty: DROP -> Underflow=1, depth=0. Then BINOP with 1 entry -> depth stays 1, op_err=1. err_clear -> both flags 0.
- err_clear together with an overflowing PUSH -> Overflow stays 1, Underflow cleared.
- Push 3 entries, assert reset low mid-cycle (asynchronously) -> depth=0, outA=0 before the next edge. After release, PUSH 7 -> outA=7, outB=0.
